// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants and types for the hex digit scanner
package hex_display_pkg;
   localparam int DIGIT_W         = 4;
   localparam int MAX_DIGITS      = 16;
   localparam int DEF_NUM_DIGITS  = 8;
   localparam int DEF_REFRESH_DIV = 50000;

   // Wide enough for the largest legal bank; users slice down to NUM_DIGITS.
   localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

   typedef logic [DIGIT_W-1:0] nibble_t;
endpackage

// File: rtl/refresh_prescaler.sv
// rtl/refresh_prescaler.sv - free-running divider, one-cycle tick every REFRESH_DIV clocks
module refresh_prescaler
   import hex_display_pkg::*;
#(
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_o
);
   localparam int               CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tick_o = (count_q == LAST);

   always_comb begin
      count_d = count_q + 1'b1;
      if (tick_o) count_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end
endmodule

// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - tear-free multiplexed scan of a hex value onto a common-anode bank
module hex_display_scanner
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] value_i,
   input  logic                          value_we,
   output logic                          pending_o,
   output nibble_t                       nibble_o,
   output logic [NUM_DIGITS-1:0]         digit_an_o,
   output logic                          blank_o,
   output logic                          frame_o
);
   localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   typedef nibble_t [NUM_DIGITS-1:0] digits_t;

   logic             tick;
   logic             boundary;
   logic [IDX_W-1:0] idx_q, idx_d;
   digits_t          display_q, display_d;
   digits_t          pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             frame_q;
   logic             upper_zero;

   refresh_prescaler #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .tick_o  (tick)
   );

   assign boundary = tick && (idx_q == LAST_IDX);

   always_comb begin
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
   end

   // Display only ever changes at a boundary; a write landing on the boundary bypasses the holding register.
   always_comb begin
      display_d  = display_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      if (boundary) begin
         if (value_we)    display_d = value_i;
         else if (pend_q) display_d = pend_val_q;
         pend_d = 1'b0;
      end else if (value_we) begin
         pend_val_d = value_i;
         pend_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q      <= '0;
         display_q  <= '0;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         display_q  <= display_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         frame_q    <= boundary;
      end
   end

   // A slot is dark when it and every digit to its left are zero; digit 0 always lights.
   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= int'(idx_q) && display_q[i] != '0) upper_zero = 1'b0;
      end
      blank_o    = LZ_BLANK && (idx_q != '0) && upper_zero;
      digit_an_o = ANODE_OFF[NUM_DIGITS-1:0];
      if (!blank_o) digit_an_o[idx_q] = 1'b0;
   end

   assign nibble_o  = display_q[idx_q];
   assign pending_o = pend_q;
   assign frame_o   = frame_q;
endmodule
